// File: rtl/panxi_clk_pkg.sv
// Shared clock-gating definitions: FSM state encoding and parameter defaults.
package panxi_clk_pkg;

    localparam int unsigned IDLE_CYCLES_DEF = 16;
    localparam int unsigned WAKE_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StIdle     = 3'd1,
        StSleepReq = 3'd2,
        StSleep    = 3'd3,
        StWake     = 3'd4
    } state_e;

    // Idle counter width; a single idle cycle still needs a 1-bit counter.
    function automatic int unsigned idle_cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-gate controller: idles, requests sleep, gates the clock and settles on wake.
// Optional sleep-event counter is enabled with the CLK_GATE_CTRL_STATS_EN macro.
module clk_gate_ctrl
    import panxi_clk_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int unsigned WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_xi,
    input  logic             rst_n_xi,
    input  logic             busy_xi,
    input  logic             wake_xi,
    input  logic             force_on_xi,
    input  logic             sleep_ack_xi,
    output logic             sleep_req_xo,
    output logic             local_en_xo,
    output logic             awake_xo
`ifdef CLK_GATE_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] sleep_cnt_xo
`endif
);

    localparam int unsigned      IdleW    = idle_cnt_w(IDLE_CYCLES);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);
    localparam logic [3:0]       WakeLast = 4'(WAKE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]       wake_cnt_q, wake_cnt_d;
    logic             local_en_q, awake_q, sleep_req_q;
    logic             wake_cond;

    assign wake_cond = busy_xi | wake_xi | force_on_xi;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            StRun: begin
                if (!wake_cond) state_d = StIdle;
            end
            StIdle: begin
                if (wake_cond) begin
                    state_d = StRun;
                end else if (idle_cnt_q == IdleLast) begin
                    state_d = StSleepReq;
                end else begin
                    idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end
            end
            StSleepReq: begin
                // A wake condition wins over a simultaneous ack.
                if (wake_cond) begin
                    state_d = StRun;
                end else if (sleep_ack_xi) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                if (wake_cond) state_d = StWake;
            end
            StWake: begin
                if (wake_cnt_q == WakeLast) begin
                    state_d = StRun;
                end else begin
                    wake_cnt_d = wake_cnt_q + 4'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_ff @(posedge clk_xi or negedge rst_n_xi) begin
        if (!rst_n_xi) begin
            state_q     <= StRun;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            local_en_q  <= 1'b1;
            awake_q     <= 1'b1;
            sleep_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            local_en_q  <= (state_d != StSleep);
            awake_q     <= (state_d == StRun) || (state_d == StIdle) || (state_d == StSleepReq);
            sleep_req_q <= (state_d == StSleepReq);
        end
    end

    assign sleep_req_xo = sleep_req_q;
    assign local_en_xo  = local_en_q;
    assign awake_xo     = awake_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [CNT_W-1:0] sleep_cnt_q;

    always_ff @(posedge clk_xi or negedge rst_n_xi) begin
        if (!rst_n_xi) begin
            sleep_cnt_q <= '0;
        end else if ((state_q == StSleepReq) && (state_d == StSleep)) begin
            sleep_cnt_q <= sleep_cnt_q + 1'b1;
        end
    end

    assign sleep_cnt_xo = sleep_cnt_q;
`endif

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 16: consecutive non-busy cycles required before a sleep request; legal range 1..255.
REQ-002 Parameter WAKE_CYCLES, default 2: settling cycles after the clock enable is restored before awake is reported; legal range 1..15.
REQ-003 Parameter CNT_W, default 16: width of the sleep-event counter.
REQ-004 clk_xi input 1: free-running ungated clock; all state is on its rising edge.
REQ-005 rst_n_xi input 1: asynchronous active-low reset.
REQ-006 busy_xi input 1: the gated module has outstanding work.
REQ-007 wake_xi input 1: external wake request, level-sensitive.
REQ-008 force_on_xi input 1: debug/scan override that forces the clock on.
REQ-009 sleep_ack_xi input 1: the gated module accepts the sleep request; sampled only in SLEEP_REQ.
REQ-010 sleep_req_xo output 1: request to the gated module to quiesce.
REQ-011 local_en_xo output 1: clock enable driven to the downstream gated-clock cell's local_en.
REQ-012 awake_xo output 1: the gated clock is running and stable.
REQ-013 sleep_cnt_xo output CNT_W: number of completed entries into SLEEP; present only under CLK_GATE_CTRL_STATS_EN.

Function
REQ-014 The FSM SHALL have exactly five states: RUN, IDLE, SLEEP_REQ, SLEEP, WAKE.
REQ-015 RUN: local_en=1, awake=1; go to IDLE when busy=0, wake=0 and force_on=0.
REQ-016 IDLE: local_en=1, awake=1, idle counter increments each cycle.
REQ-017 IDLE SHALL return to RUN and clear the counter on any of busy, wake or force_on.
REQ-018 IDLE SHALL go to SLEEP_REQ on the cycle the counter reaches IDLE_CYCLES-1 with no wake condition, giving exactly IDLE_CYCLES idle cycles.
REQ-019 SLEEP_REQ: sleep_req=1, local_en=1, awake=1.
REQ-020 SLEEP_REQ with sleep_ack=1 and no wake condition SHALL go to SLEEP.
REQ-021 SLEEP_REQ with busy, wake or force_on SHALL go to RUN; a wake condition overrides a simultaneous ack.
REQ-022 SLEEP: local_en=0, awake=0, sleep_req=0.
REQ-023 SLEEP SHALL go to WAKE when busy, wake or force_on is asserted.
REQ-024 WAKE: local_en=1, awake=0; a settle counter counts WAKE_CYCLES cycles, then the FSM goes to RUN.
REQ-025 Wake conditions during WAKE SHALL be ignored; the state SHALL not re-enter SLEEP.
REQ-026 All outputs SHALL be registered (Moore); latency from a wake condition in SLEEP to local_en=1 SHALL be 1 cycle, and to awake=1 SHALL be WAKE_CYCLES+1 cycles.
REQ-027 sleep_req SHALL drop in the same cycle the FSM leaves SLEEP_REQ.
REQ-028 force_on=1 SHALL hold local_en=1 in every state from the next cycle onward.
REQ-029 The idle counter SHALL be sized to clog2(IDLE_CYCLES) bits and SHALL saturate, never wrap.

Reset
REQ-030 Asynchronous reset SHALL place the FSM in RUN with local_en=1, awake=1, sleep_req=0, all counters 0 and sleep_cnt 0.
REQ-031 Reset asserted mid-SLEEP or mid-WAKE SHALL take effect immediately; the clock SHALL come up enabled when reset releases.

Configuration
REQ-032 Macro CLK_GATE_CTRL_STATS_EN defined: sleep_cnt_xo exists and increments on each SLEEP_REQ->SLEEP transition, wrapping at 2^CNT_W.
REQ-033 Macro CLK_GATE_CTRL_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

Structure
REQ-034 The state encoding enum and the IDLE_CYCLES/WAKE_CYCLES defaults SHALL live in the shared package panxi_clk_pkg.
REQ-035 The design SHALL be a single module with no sub-modules; its local_en_xo feeds the gated_clk cell at the integration level.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Reset, then busy=0: at cycle 16 sleep_req=1; sleep_ack=1 -> local_en=0 next cycle, sleep_cnt=1.
- busy pulses at idle cycle 10 -> back to RUN, counter cleared, no sleep_req for 16 more cycles.
- In SLEEP, wake=1 for one cycle -> local_en=1 after 1 cycle, awake=1 after 3 cycles (WAKE_CYCLES=2), then RUN.
- In SLEEP_REQ, wake=1 and sleep_ack=1 together -> RUN, local_en stays 1, sleep_cnt unchanged.
- force_on=1 throughout -> never leaves RUN; local_en=1 at all times.
- rst_n_xi asserted while in SLEEP -> local_en=1 and awake=1 asynchronously, with state RUN after release.
